// File: rtl/l2_bus_arbiter.sv
// rtl/l2_bus_arbiter.sv - two-core round-robin arbiter and sequencer for the shared L2 bus
// Registers every L2-side and core-side output; core fields are latched at grant.
module l2_bus_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [6:0]  opcode0,
  input  logic [31:0] addr0,
  input  logic [31:0] data0,
  input  logic [23:0] tag0,
  output logic        ack0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic [6:0]  opcode1,
  input  logic [31:0] addr1,
  input  logic [31:0] data1,
  input  logic [23:0] tag1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic [6:0]  opcode_to_L2,
  output logic [31:0] bus_address_out,
  output logic [31:0] bus_data_out,
  output logic [23:0] bus_tag_out,
  output logic        flush_out,
  input  logic [1:0]  cache_hit_in,
  input  logic [31:0] data_from_L2,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_FLUSH = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               rr_q, rr_d;
  logic               gid_q, gid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [6:0]         op_q, op_d;
  logic [6:0]         l2_op_q, l2_op_d;
  logic [31:0]        l2_addr_q, l2_addr_d;
  logic [31:0]        l2_data_q, l2_data_d;
  logic [23:0]        l2_tag_q, l2_tag_d;
  logic               flush_q, flush_d;
  logic               ack0_q, ack0_d, ack1_q, ack1_d;
  logic [31:0]        rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic               err0_q, err0_d, err1_q, err1_d;

  logic               gnt;
  logic [6:0]         sel_op;
  logic [31:0]        sel_addr, sel_data;
  logic [23:0]        sel_tag;
  logic               finish, fin_err;
  logic [31:0]        fin_rdata;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gid_d     = gid_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    l2_op_d   = l2_op_q;
    l2_addr_d = l2_addr_q;
    l2_data_d = l2_data_q;
    l2_tag_d  = l2_tag_q;
    flush_d   = flush_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    err0_d    = err0_q;
    err1_d    = err1_q;
    finish    = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;
    cnt_inc   = cnt_q + CNT_W'(1);

    gnt      = (req0 && req1) ? rr_q : req1;
    sel_op   = gnt ? opcode1 : opcode0;
    sel_addr = gnt ? addr1   : addr0;
    sel_data = gnt ? data1   : data0;
    sel_tag  = gnt ? tag1    : tag0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_ISSUE;
          busy_d  = 1'b1;
          gid_d   = gnt;
          op_d    = sel_op;
          // Unknown opcodes leave the bus at its idle zero value.
          if (sel_op == OP_LOAD || sel_op == OP_FLUSH) begin
            l2_op_d   = sel_op;
            l2_addr_d = sel_addr;
            l2_data_d = sel_data;
            l2_tag_d  = sel_tag;
            flush_d   = (sel_op == OP_FLUSH);
          end
        end
      end
      S_ISSUE: begin
        if (op_q == OP_LOAD) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          finish  = 1'b1;
          fin_err = (op_q != OP_FLUSH);
        end
      end
      S_WAIT: begin
        if (cache_hit_in == 2'b10) begin
          finish    = 1'b1;
          fin_rdata = data_from_L2;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            finish  = 1'b1;
            fin_err = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        gid_d   = 1'b0;
        rr_d    = ~gid_q;
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d   = S_DONE;
      l2_op_d   = '0;
      l2_addr_d = '0;
      l2_data_d = '0;
      l2_tag_d  = '0;
      flush_d   = 1'b0;
      if (gid_q) begin
        ack1_d   = 1'b1;
        rdata1_d = fin_rdata;
        err1_d   = fin_err;
      end else begin
        ack0_d   = 1'b1;
        rdata0_d = fin_rdata;
        err0_d   = fin_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      gid_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      op_q      <= '0;
      l2_op_q   <= '0;
      l2_addr_q <= '0;
      l2_data_q <= '0;
      l2_tag_q  <= '0;
      flush_q   <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gid_q     <= gid_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      l2_op_q   <= l2_op_d;
      l2_addr_q <= l2_addr_d;
      l2_data_q <= l2_data_d;
      l2_tag_q  <= l2_tag_d;
      flush_q   <= flush_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  assign ack0            = ack0_q;
  assign rdata0          = rdata0_q;
  assign err0            = err0_q;
  assign ack1            = ack1_q;
  assign rdata1          = rdata1_q;
  assign err1            = err1_q;
  assign opcode_to_L2    = l2_op_q;
  assign bus_address_out = l2_addr_q;
  assign bus_data_out    = l2_data_q;
  assign bus_tag_out     = l2_tag_q;
  assign flush_out       = flush_q;
  assign busy            = busy_q;
  assign grant_id        = gid_q;

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// tb/tb_l2_bus_arbiter.sv - randomized scoreboard bench for l2_bus_arbiter
module tb_l2_bus_arbiter;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] FLUSH = 7'b0100011;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [6:0]  opcode0 = '0, opcode1 = '0;
  logic [31:0] addr0 = '0, addr1 = '0, data0 = '0, data1 = '0;
  logic [23:0] tag0 = '0, tag1 = '0;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [6:0]  opcode_to_L2;
  logic [31:0] bus_address_out, bus_data_out;
  logic [23:0] bus_tag_out;
  logic        flush_out, busy, grant_id;
  logic [1:0]  cache_hit_in = 2'b00;
  logic [31:0] data_from_L2 = '0;

  l2_bus_arbiter #(.TIMEOUT(TMO), .CNT_W(7)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .opcode0(opcode0), .addr0(addr0), .data0(data0), .tag0(tag0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .opcode1(opcode1), .addr1(addr1), .data1(data1), .tag1(tag1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .opcode_to_L2(opcode_to_L2), .bus_address_out(bus_address_out),
    .bus_data_out(bus_data_out), .bus_tag_out(bus_tag_out), .flush_out(flush_out),
    .cache_hit_in(cache_hit_in), .data_from_L2(data_from_L2),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [23:0] tag;
    int          miss;
    logic [31:0] hd;
  } txn_t;

  typedef struct {
    int          core;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [23:0] tag;
    int          cyc;
  } fexp_t;

  exp_t        exp_q[$];
  fexp_t       fq[$];
  int          checks = 0, errors = 0;
  int          rr_m = 0;
  logic [31:0] m_rd[2] = '{32'h0, 32'h0};
  logic        m_err[2] = '{1'b0, 1'b0};
  int          cfg_miss[2] = '{0, 0};
  logic [31:0] cfg_hd[2] = '{32'h0, 32'h0};
  bit          mon_en = 1'b0;
  int          lcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [6:0] op, input logic [31:0] a, input logic [31:0] d,
                              input logic [23:0] t, input int miss, input logic [31:0] hd);
    txn_t x;
    x.op = op; x.addr = a; x.data = d; x.tag = t; x.miss = miss; x.hd = hd;
    return x;
  endfunction

  // Cycles from the granting edge to the edge that raises ack.
  function automatic int lat(input txn_t t);
    if (t.op != LOAD) return 1;
    if (t.miss >= TMO) return TMO + 1;
    return 2 + t.miss;
  endfunction

  task automatic push_exp(input int core, input txn_t t, input int g, output int ack_cyc);
    exp_t e;
    fexp_t f;
    ack_cyc = g + lat(t);
    e.core = core;
    e.cyc = ack_cyc;
    if (t.op == LOAD) begin
      e.err = (t.miss >= TMO);
      e.rdata = (t.miss >= TMO) ? 32'h0 : t.hd;
    end else begin
      e.err = (t.op != FLUSH);
      e.rdata = 32'h0;
    end
    exp_q.push_back(e);
    if (t.op == FLUSH) begin
      f.addr = t.addr; f.data = t.data; f.tag = t.tag; f.cyc = g;
      fq.push_back(f);
    end
  endtask

  task automatic run_round(input bit u0, input bit u1, input txn_t t0, input txn_t t1);
    int first, a;
    @(posedge clk); #1;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    cfg_miss[0] = t0.miss; cfg_hd[0] = t0.hd;
    cfg_miss[1] = t1.miss; cfg_hd[1] = t1.hd;
    if (u0) begin req0 = 1; opcode0 = t0.op; addr0 = t0.addr; data0 = t0.data; tag0 = t0.tag; end
    if (u1) begin req1 = 1; opcode1 = t1.op; addr1 = t1.addr; data1 = t1.data; tag1 = t1.tag; end
    first = (u0 && u1) ? rr_m : (u1 ? 1 : 0);
    push_exp(first, first ? t1 : t0, cyc + 1, a);
    rr_m = 1 - first;
    if (u0 && u1) begin
      push_exp(1 - first, first ? t0 : t1, a + 2, a);
      rr_m = first;
    end
    for (int i = 0; i < 400 && (req0 || req1); i++) begin
      @(posedge clk); #1;
      if (ack0) req0 = 0;
      if (ack1) req1 = 0;
    end
    chk("round_complete", {req1, req0}, 2'b00);
    req0 = 0; req1 = 0;
  endtask

  function automatic txn_t rand_txn();
    txn_t x;
    int r, k;
    r = $urandom_range(0, 9);
    if (r < 6) x.op = LOAD;
    else if (r < 8) x.op = FLUSH;
    else begin
      x.op = 7'($urandom);
      if (x.op == LOAD || x.op == FLUSH) x.op = 7'b0110011;
    end
    x.addr = $urandom; x.data = $urandom; x.tag = 24'($urandom); x.hd = $urandom;
    k = $urandom_range(0, 19);
    x.miss = (k < 16) ? $urandom_range(0, 6) : ((k < 18) ? TMO - 1 : TMO);
    return x;
  endfunction

  // L2 model: idle during ISSUE, then miss for cfg_miss WAIT cycles, then hit.
  always @(posedge clk) begin
    #1;
    if (opcode_to_L2 == LOAD) lcnt++;
    else lcnt = 0;
    if (lcnt >= 2 && lcnt - 2 >= cfg_miss[grant_id]) begin
      cache_hit_in = 2'b10;
      data_from_L2 = cfg_hd[grant_id];
    end else begin
      cache_hit_in = (lcnt >= 2) ? 2'b01 : 2'b00;
      data_from_L2 = $urandom;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    fexp_t f;
    if (mon_en) begin
      if (ack0 || ack1) begin
        chk("ack_onehot", {31'h0, ack0 & ack1}, 0);
        chk("ack_l2_quiet", {63'h0, |{opcode_to_L2, bus_address_out, bus_data_out, bus_tag_out, flush_out}}, 0);
        if (exp_q.size() == 0) chk("spurious_ack", {ack1, ack0}, 0);
        else begin
          e = exp_q.pop_front();
          chk("ack_core", ack1, e.core[0]);
          chk("ack_cycle", cyc, e.cyc);
          m_rd[e.core] = e.rdata;
          m_err[e.core] = e.err;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        e = exp_q.pop_front();
        chk("ack_missing", {ack1, ack0}, (e.core == 1) ? 2 : 1);
        m_rd[e.core] = e.rdata;
        m_err[e.core] = e.err;
      end
      if (flush_out) begin
        if (fq.size() == 0) chk("spurious_flush", flush_out, 0);
        else begin
          f = fq.pop_front();
          chk("flush_cycle", cyc, f.cyc);
          chk("flush_opcode", opcode_to_L2, FLUSH);
          chk("flush_addr", bus_address_out, f.addr);
          chk("flush_data", bus_data_out, f.data);
          chk("flush_tag", bus_tag_out, f.tag);
        end
      end else if (fq.size() > 0 && cyc > fq[0].cyc) begin
        f = fq.pop_front();
        chk("flush_missing", flush_out, 1);
      end
      chk("rdata0", rdata0, m_rd[0]);
      chk("err0", err0, m_err[0]);
      chk("rdata1", rdata1, m_rd[1]);
      chk("err1", err1, m_err[1]);
      if (!busy)
        chk("idle_outputs", {63'h0, |{opcode_to_L2, bus_address_out, bus_data_out, bus_tag_out,
                                     flush_out, grant_id, ack0, ack1}}, 0);
      if (opcode_to_L2 != 0)
        chk("l2_opcode_legal", {63'h0, opcode_to_L2 == LOAD || opcode_to_L2 == FLUSH}, 1);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t n;
    n = mk(LOAD, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {63'h0, |{ack0, ack1, rdata0, rdata1, err0, err1, opcode_to_L2, bus_address_out,
                                  bus_data_out, bus_tag_out, flush_out, busy, grant_id}}, 0);
    reset = 0;
    mon_en = 1;

    run_round(1, 0, mk(LOAD, 32'h0000_0040, 0, 0, 0, 32'hDEAD_BEEF), n);
    run_round(0, 1, n, mk(FLUSH, 32'h0000_0104, 32'h1234_5678, 24'hABCDEF, 0, 0));
    run_round(1, 1, mk(LOAD, 32'h100, 0, 0, 1, 32'h1111_0000), mk(LOAD, 32'h200, 0, 0, 2, 32'h2222_0000));
    run_round(1, 0, mk(LOAD, 32'h300, 0, 0, 0, 32'h3333_0000), n);
    run_round(1, 1, mk(LOAD, 32'h400, 0, 0, 0, 32'h4444_0000), mk(LOAD, 32'h500, 0, 0, 0, 32'h5555_0000));
    run_round(0, 1, n, mk(LOAD, 32'h600, 0, 0, 5, 32'h0000_00AA));
    run_round(1, 0, mk(LOAD, 32'h700, 0, 0, TMO, 32'h7777_7777), n);
    run_round(0, 1, n, mk(LOAD, 32'h800, 0, 0, TMO - 1, 32'h8888_0001));
    run_round(1, 0, mk(7'b0110011, 32'h900, 32'h9, 24'h9, 0, 0), n);

    // Abort a load mid-WAIT; rr must come back as core 0.
    run_round(1, 0, mk(FLUSH, 32'hA00, 32'hA, 24'hA, 0, 0), n);
    @(posedge clk); #1;
    cfg_miss[0] = 1000;
    req0 = 1; opcode0 = LOAD; addr0 = 32'hB00;
    repeat (6) begin @(posedge clk); #1; end
    chk("busy_before_reset", busy, 1);
    reset = 1;
    exp_q.delete();
    fq.delete();
    @(posedge clk); #1;
    chk("midreset_outputs", {63'h0, |{ack0, ack1, rdata0, rdata1, err0, err1, opcode_to_L2, bus_address_out,
                                     bus_data_out, bus_tag_out, flush_out, busy, grant_id}}, 0);
    m_rd[0] = 0; m_rd[1] = 0; m_err[0] = 0; m_err[1] = 0;
    rr_m = 0;
    reset = 0;
    req0 = 0;
    run_round(1, 1, mk(LOAD, 32'hC00, 0, 0, 0, 32'hC0C0_C0C0), mk(LOAD, 32'hD00, 0, 0, 1, 32'hD0D0_D0D0));

    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 2);
      run_round(k != 1, k != 0, rand_txn(), rand_txn());
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size() + fq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_bus_arbiter.md
Name: l2_bus_arbiter

Overview:
Two-core round-robin arbiter and sequencer in front of the shared L2 cache subsystem. Accepts L1-side requests from core 0 and core 1: loads on an L1 miss, and flush/writeback stores. Grants one requester at a time and drives the L2 bus signals (opcode, address, data, tag, flush). For loads, waits for the L2 hit indication, including any L2 miss/DMEM refill, then returns read data with a one-cycle ack.

Parameters:
TIMEOUT, 64, number of WAIT cycles without an L2 hit before the load is aborted with an error
CNT_W, 7, width of the wait counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
req0  in  1  core 0 request; held high with fields stable until ack0
opcode0  in  7  core 0 opcode: 7'b0000011 load, 7'b0100011 flush/writeback
addr0  in  32  core 0 byte address
data0  in  32  core 0 write data (flush only)
tag0  in  24  core 0 L1 tag (flush only)
ack0  out  1  one-cycle completion pulse to core 0
rdata0  out  32  load data to core 0; valid while ack0=1
err0  out  1  error flag; valid while ack0=1
req1, opcode1, addr1, data1, tag1, ack1, rdata1, err1  same as the core 0 ports, for core 1
opcode_to_L2  out  7  opcode presented to L2
bus_address_out  out  32  address to L2
bus_data_out  out  32  data to L2
bus_tag_out  out  24  tag to L2
flush_out  out  1  L2 flush strobe
cache_hit_in  in  2  L2 status: 2'b10 hit, 2'b01 miss, 2'b00 idle
data_from_L2  in  32  L2 read data
busy  out  1  high in any state other than IDLE
grant_id  out  1  index of the core currently granted; 0 in IDLE

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset).
- Reset:
  - state=IDLE, rr_ptr=0, wait counter=0.
  - All outputs 0, including ack*, rdata*, err*, all L2-side signals, busy and grant_id.
  - Reset mid-transaction aborts it silently: no ack, flush_out drops immediately.
- State machine: IDLE, ISSUE, WAIT, DONE. All L2-side outputs are registered from latched request fields.
- IDLE:
  - If exactly one req is high, grant that core.
  - If both are high, grant core rr_ptr.
  - On grant, latch opcode/addr/data/tag/core id and go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Drive opcode_to_L2, bus_address_out, bus_data_out, bus_tag_out from the latched fields.
  - Flush: flush_out=1 for this single cycle only, then go to DONE with err=0.
  - Load: flush_out=0, clear the wait counter, go to WAIT.
  - Any other opcode: drive no L2 activity (opcode_to_L2=0), go to DONE with err=1.
- WAIT:
  - Keep driving the load opcode and address.
  - At each posedge, if cache_hit_in==2'b10, capture data_from_L2 into the granted rdata and go to DONE with err=0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to DONE with rdata=0 and err=1.
  - cache_hit_in==2'b01 (L2 miss, refill in progress) is not an error; keep waiting.
- DONE (exactly 1 cycle):
  - Granted ack=1, other ack=0.
  - All L2-side outputs are 0.
  - rr_ptr becomes the non-granted core. Return to IDLE.
- Latency, counted from the posedge that samples req in IDLE:
  - Flush: ack high in the 2nd cycle after that edge.
  - Load that hits L2 immediately: ack in the 3rd cycle.
  - Load that misses: ack in cycle 3 + number of miss cycles.
- Requester rules:
  - A requester drops req in the cycle after ack.
  - A req still high in IDLE after DONE is treated as a new request.
  - Req inputs are ignored outside IDLE; a losing requester simply waits.
- Ack outputs: rdata*/err* hold their value after ack until that core's next ack. The non-granted core's rdata/err are never modified.
- grant_id = latched core id in ISSUE/WAIT/DONE, 0 in IDLE.

Test Plan:
1. Reset, then req0 load addr=32'h0000_0040 with L2 model returning hit=10, data=32'hDEAD_BEEF in WAIT -> ack0 in 3rd cycle with rdata0=32'hDEAD_BEEF, err0=0; ack1 stays 0.
2. req1 flush addr=32'h0000_0104, data=32'h1234_5678, tag=24'hABCDEF -> flush_out=1 for exactly one cycle with those values on the bus; ack1 in 2nd cycle.
3. req0 and req1 both asserted with loads after reset -> core0 served first, then core1; next simultaneous pair -> core1 served first.
4. Load where the L2 model returns 01 for 5 cycles, then 10 with data 32'h0000_00AA -> ack after 5 extra cycles, rdata=32'h0000_00AA, err=0.
5. Load where the L2 model never returns 10 -> after 64 WAIT cycles ack with err=1, rdata=0. Opcode 7'b0110011 -> ack in 2nd cycle with err=1 and no L2 activity.
6. Reset asserted during WAIT -> next cycle state IDLE, all outputs 0, no ack; a new req0 is served normally with rr_ptr=0.
